// File: rtl/rrf_retire_wr.sv
// Retire-side write scheduler: buffers ROB retire bundles in a small FIFO and
// drains one bundle per enabled cycle onto the 9 register-file write ports.
module rrf_retire_wr #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned EXTRA      = 0,
  parameter int unsigned DEPTH      = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [8:0]                 in_wen,
  input  logic [53:0]                in_addr,
  input  logic [9*DATA_WIDTH-1:0]    in_data,
  input  logic                       in_thread,
  input  logic                       drain_en,
  input  logic                       flush,
  output logic [8:0]                 wr_wen,
  output logic [53:0]                wr_addr,
  output logic [9*DATA_WIDTH-1:0]    wr_data,
  output logic                       wr_thread,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       addr_err
);

  localparam int unsigned SLOTS = 9;
  localparam int unsigned AW    = 6;
  localparam int unsigned AW1   = AW + 1;
  localparam int unsigned PW    = $clog2(DEPTH);
  localparam int unsigned CW    = PW + 1;
  localparam int unsigned DW    = SLOTS * DATA_WIDTH;
  localparam int unsigned LIMIT = 32 + 16 * EXTRA;

  logic [SLOTS-1:0]    mem_wen    [DEPTH];
  logic [SLOTS*AW-1:0] mem_addr   [DEPTH];
  logic [DW-1:0]       mem_data   [DEPTH];
  logic                mem_thread [DEPTH];

  logic [PW-1:0]       wr_ptr;
  logic [PW-1:0]       rd_ptr;
  logic                push;
  logic                pop;
  logic [SLOTS-1:0]    in_wen_ok;
  logic                range_bad;
  logic [SLOTS-1:0]    head_wen;
  logic [SLOTS*AW-1:0] head_addr;
  logic [SLOTS-1:0]    head_keep;

  assign in_ready = (count < CW'(DEPTH));
  assign push     = in_valid && in_ready && !flush;
  assign pop      = drain_en && (count != '0) && !flush;

  // Out-of-range slots are disabled before they ever enter the FIFO.
  always_comb begin
    in_wen_ok = in_wen;
    range_bad = 1'b0;
    for (int unsigned k = 0; k < SLOTS; k++) begin
      if (in_wen[k] && ({1'b0, in_addr[k*AW +: AW]} >= AW1'(LIMIT))) begin
        in_wen_ok[k] = 1'b0;
        range_bad    = 1'b1;
      end
    end
  end

  // Youngest (highest-index) writer of an address wins; older duplicates are killed.
  always_comb begin
    head_wen  = mem_wen[rd_ptr];
    head_addr = mem_addr[rd_ptr];
    head_keep = head_wen;
    for (int unsigned i = 0; i < SLOTS; i++) begin
      for (int unsigned j = i + 1; j < SLOTS; j++) begin
        if (head_wen[j] && (head_addr[j*AW +: AW] == head_addr[i*AW +: AW])) begin
          head_keep[i] = 1'b0;
        end
      end
    end
  end

  // Bundle storage; no reset needed since count gates every read.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_wen[wr_ptr]    <= in_wen_ok;
      mem_addr[wr_ptr]   <= in_addr;
      mem_data[wr_ptr]   <= in_data;
      mem_thread[wr_ptr] <= in_thread;
    end
  end

  // Pointers, occupancy, write-port registers and the sticky error flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      wr_wen    <= '0;
      wr_addr   <= '0;
      wr_data   <= '0;
      wr_thread <= 1'b0;
      addr_err  <= 1'b0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      wr_wen <= '0;
    end else begin
      wr_wen <= '0;
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
        if (range_bad) addr_err <= 1'b1;
      end
      if (pop) begin
        rd_ptr    <= rd_ptr + PW'(1);
        wr_wen    <= head_keep;
        wr_addr   <= head_addr;
        wr_data   <= mem_data[rd_ptr];
        wr_thread <= mem_thread[rd_ptr];
      end
      if (push && !pop) begin
        count <= count + CW'(1);
      end else if (pop && !push) begin
        count <= count - CW'(1);
      end
    end
  end

endmodule
